ula_mul_div: RTL and testbench
==============================

# ula_mul_div

Sequential, parametrised ALU for the MIPS datapath. It executes the single-cycle logic, arithmetic and compare operations with a registered result, and adds iterative signed/unsigned multiply and divide into architectural HI/LO registers. The block sits in the EX stage. The control unit stalls the pipeline on `busy` and consumes results on `done`.

## Interface
Parameters:
- `WIDTH`, 32: operand, result, HI and LO width. Must be ≥ 4.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  request; `op`/`a`/`b` are sampled when `start` is high and `busy` is low.
- `op`  in  4  operation select (codes under Operation).
- `a`, `b`  in  WIDTH  operands.
- `s`  out  WIDTH  registered result.
- `z`  out  1  high when `s` equals 0.
- `ovf`  out  1  signed overflow of ADD/SUB; 0 for every other operation.
- `hi`, `lo`  out  WIDTH  HI/LO registers.
- `busy`  out  1  multiply/divide in progress.
- `done`  out  1  one-cycle pulse when the result of an accepted request is valid.
- `div_zero`  out  1  set with `done` when a divide had `b == 0`.

## Operation
- **Opcodes:**
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR
  - 0100 ADDU; 0101 SUBU; 0110 SUB; 0111 SLT
  - 1011 SLTU; 1100 NOR
  - 1000 MULT; 1001 MULTU; 1010 DIV; 1101 DIVU
  - 1110 MFHI (`s = hi`); 1111 MFLO (`s = lo`)
  - Any other code: `s = 0`, single-cycle.
- **Arithmetic:** ADD/SUB/ADDU/SUBU wrap modulo 2^WIDTH. `ovf` is set only for ADD/SUB when the operand signs make the result sign wrong. SLT compares two's-complement; SLTU compares raw bits. `s` is 1 or 0.
- **Multiply:** shift-add on magnitudes, one bit per cycle over WIDTH iterations. The 2·WIDTH product goes to `{hi, lo}`. MULT negates the product when `a[WIDTH-1] ^ b[WIDTH-1]`.
- **Divide:** restoring division on magnitudes, WIDTH iterations.
  - `lo` = quotient, `hi` = remainder.
  - Signed: quotient sign is `a ^ b`; remainder takes the sign of `a`. MOST_NEG / -1 gives `lo = MOST_NEG`, `hi = 0`.
  - `b == 0`: no iteration, `hi`/`lo` unchanged, `div_zero = 1`.
- **Result registers:** multiply/divide leave `s` and `ovf` at 0 and update `z` from `s`. `div_zero` is 0 on every `done` except divide-by-zero. `hi`/`lo` change only at multiply/divide completion.
- **FSM** (`IDLE`, `RUN`):
  - `IDLE` + accepted multiply/divide with a nonzero divisor → `RUN`; iteration counter = 0.
  - `RUN` → `IDLE` after the counter reaches WIDTH-1; `hi`/`lo` are written on that edge.
  - All other accepted requests stay in `IDLE`.

## Timing
- **Reset:** all outputs 0 (`s`, `z`, `ovf`, `hi`, `lo`, `busy`, `done`, `div_zero`); FSM in `IDLE`; counter 0.
  - `z` is 0 while in reset and is recomputed from the first accepted request.
  - Reset during `RUN` aborts the operation. No `done` is produced, and `hi`/`lo` are cleared.
- **Single-cycle ops and divide-by-zero:** accepted at edge E0; `s`/`z`/`ovf`/`div_zero` and `done = 1` are visible after E0 (latency 1).
- **Multiply/divide:** accepted at E0.
  - `busy = 1` for the WIDTH cycles after E0.
  - At edge E_WIDTH: `busy` falls, `done = 1` for one cycle, `hi`/`lo` are valid.
- **Back-to-back:** a new request may be accepted in the same cycle as `done`.
- **Ignored requests:** `start` while `busy` is ignored and produces no `done`. `op`/`a`/`b` may change freely during `RUN`; operands are latched at E0.
- **Idle outputs:** `done` is 0 in any cycle without a completion. `s` holds its last value.

## Configuration
- **`ULA_DIV_EN` defined:** divider logic is compiled in; DIV/DIVU behave as specified above.
- **`ULA_DIV_EN` undefined:**
  - Opcodes 1010/1101 are treated as unknown: `s = 0`, latency 1, `div_zero = 0`, `hi`/`lo` unchanged.
  - Multiply is unaffected.

## Structure
- **Package `ula_pkg`:** opcode localparams (`OP_AND` … `OP_MFLO`) and the FSM state encoding (`ST_IDLE`, `ST_RUN`).
- **Sub-module `ula_md_iter`:** holds the multiply/divide iteration datapath and counter, plus the sign pre- and post-processing.
  - Interface: `load`, `is_div`, `is_signed`, operands in; `fin`, `hi_out`, `lo_out` out.
- **Top level:** the single-cycle ops, handshake, FSM and output registers.

## Test plan
All scenarios use WIDTH=32.
1. ADD `a=0x7FFFFFFF`, `b=1` → next cycle `s=0x80000000`, `ovf=1`, `z=0`, `done=1`. SUB `a=5`, `b=5` → `s=0`, `z=1`, `ovf=0`.
2. MULT `a=0xFFFFFFFD` (-3), `b=7` → `busy` high 32 cycles, then `done`, `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`. Follow with MFLO → `s=0xFFFFFFEB`.
3. DIV `a=-7`, `b=2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIVU `a=7`, `b=2` → `lo=3`, `hi=1`. Both have latency 32 and `div_zero=0`.
4. DIV `b=0` → `done` after 1 cycle, `div_zero=1`, `hi`/`lo` unchanged, `busy` never high.
5. During MULTU, `start` with ADD at cycle 5 → ignored; no extra `done`. New MULTU, then `reset` at cycle 10 → next cycle all outputs 0, no `done`.
6. SLTU `a=0xFFFFFFFF`, `b=1` → `s=0`, `z=1`. SLT with the same operands → `s=1`. Without `ULA_DIV_EN`, DIV → `s=0`, latency 1.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: opcode encodings and FSM state type shared by the ula_mul_div block.
`default_nettype none

package ula_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADDU  = 4'b0100;
  localparam logic [3:0] OP_SUBU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ula_md_iter.sv
// ula_md_iter: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes.
// Divider datapath only present when ULA_DIV_EN is defined.
`default_nettype none

module ula_md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             active;
  logic             div_q;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;

  assign mag_a_in = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b_in = (is_signed && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_b  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= mag_a_in;
      mag_b  <= mag_b_in;
      div_q  <= is_div;
      neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= is_signed && a[WIDTH-1];
    end else if (active) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt + CW'(1);
      if (cnt == LAST) active <= 1'b0;
    end
  end

`ifdef ULA_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_diff;
`else
  logic unused_div;
  assign unused_div = div_q ^ neg_r;
`endif

  always_comb begin
    // Multiply step: conditionally add multiplicand, then shift {carry,hi,lo} right.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    nxt_hi  = mul_sum[WIDTH:1];
    nxt_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ULA_DIV_EN
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mag_b};
    if (div_q) begin
      nxt_hi = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~rem_diff[WIDTH]};
    end
`endif
    prod = {nxt_hi, nxt_lo};
    if (neg_q) prod = -prod;
    hi_out = prod[2*WIDTH-1:WIDTH];
    lo_out = prod[WIDTH-1:0];
`ifdef ULA_DIV_EN
    if (div_q) begin
      lo_out = neg_q ? -nxt_lo : nxt_lo;
      hi_out = neg_r ? -nxt_hi : nxt_hi;
    end
`endif
    fin = active && (cnt == LAST);
  end

endmodule

`default_nettype wire

// File: rtl/ula_mul_div.sv
// ula_mul_div: EX-stage ALU with registered result and iterative multiply/divide into HI/LO.
// Define ULA_DIV_EN to compile in DIV/DIVU; otherwise those opcodes act as unknown ops.
`default_nettype none

module ula_mul_div
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             is_div;
  logic             is_mul;
  logic             is_md;
  logic             is_signed_op;
  logic             div_by_zero;
  logic             fin;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

`ifdef ULA_DIV_EN
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign is_mul       = (op == OP_MULT) || (op == OP_MULTU);
  assign is_md        = is_mul || is_div;
  assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_by_zero  = is_div && (b == '0);
  assign busy         = (state == ST_RUN);
  assign accept       = start && !busy;
  assign sum          = a + b;
  assign diff         = a - b;

  ula_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clock     (clock),
    .reset     (reset),
    .load      (accept && is_md && !div_by_zero),
    .is_div    (is_div),
    .is_signed (is_signed_op),
    .a         (a),
    .b         (b),
    .fin       (fin),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADDU: alu_res = sum;
      OP_SUBU: alu_res = diff;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_md && !div_by_zero) state_nxt = ST_RUN;
      ST_RUN:  if (fin) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Multiply/divide requests update nothing at acceptance; results land when the iterator finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      s        <= '0;
      z        <= 1'b0;
      ovf      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (fin) begin
          hi       <= hi_out;
          lo       <= lo_out;
          s        <= '0;
          z        <= 1'b1;
          ovf      <= 1'b0;
          div_zero <= 1'b0;
          done     <= 1'b1;
        end
      end else if (start) begin
        if (div_by_zero) begin
          s        <= '0;
          z        <= 1'b1;
          ovf      <= 1'b0;
          div_zero <= 1'b1;
          done     <= 1'b1;
        end else if (!is_md) begin
          s        <= alu_res;
          z        <= (alu_res == '0);
          ovf      <= alu_ovf;
          div_zero <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_mul_div.sv
// tb_ula_mul_div: directed vectors with a scoreboard queue checked by a done-driven monitor.
`default_nettype none

module tb_ula_mul_div;

  localparam logic [3:0] T_AND = 4'b0000, T_OR = 4'b0001, T_ADD = 4'b0010, T_XOR = 4'b0011;
  localparam logic [3:0] T_ADDU = 4'b0100, T_SUBU = 4'b0101, T_SUB = 4'b0110, T_SLT = 4'b0111;
  localparam logic [3:0] T_MULT = 4'b1000, T_MULTU = 4'b1001, T_DIV = 4'b1010, T_SLTU = 4'b1011;
  localparam logic [3:0] T_NOR = 4'b1100, T_DIVU = 4'b1101, T_MFHI = 4'b1110, T_MFLO = 4'b1111;
  localparam int MD_LAT = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [31:0] s, hi, lo;
  logic        z, ovf, busy, done, div_zero;

  typedef struct {
    string       name;
    logic [31:0] s;
    logic        z;
    logic        ovf;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] exp_hi, exp_lo;

  ula_mul_div #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .s        (s),
    .z        (z),
    .ovf      (ovf),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation, including its cycle.
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".cyc"}, 64'(cyc), 64'(e.cyc));
        chk({e.name, ".s"}, 64'(s), 64'(e.s));
        chk({e.name, ".z"}, 64'(z), 64'(e.z));
        chk({e.name, ".ovf"}, 64'(ovf), 64'(e.ovf));
        chk({e.name, ".div_zero"}, 64'(div_zero), 64'(e.dz));
        chk({e.name, ".hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, ".lo"}, 64'(lo), 64'(e.lo));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic push, input logic [31:0] es, input logic eo, input logic edz,
                      input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e.name = nm; e.s = es; e.z = (es == 32'h0); e.ovf = eo; e.dz = edz;
      e.hi = ehi; e.lo = elo; e.cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic alu(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] es, input logic eo);
    send(nm, o, x, y, 1'b1, es, eo, 1'b0, 0, exp_hi, exp_lo);
  endtask

  task automatic md(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] ehi, input logic [31:0] elo);
    exp_hi = ehi; exp_lo = elo;
    send(nm, o, x, y, 1'b1, 32'h0, 1'b0, 1'b0, MD_LAT, ehi, elo);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) chk("busy_timeout", 64'(n), 64'(0));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".s"}, 64'(s), 0);
    chk({nm, ".z"}, 64'(z), 0);
    chk({nm, ".ovf"}, 64'(ovf), 0);
    chk({nm, ".hi"}, 64'(hi), 0);
    chk({nm, ".lo"}, 64'(lo), 0);
    chk({nm, ".busy"}, 64'(busy), 0);
    chk({nm, ".done"}, 64'(done), 0);
    chk({nm, ".div_zero"}, 64'(div_zero), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start = 1'b0; op = 4'h0; a = '0; b = '0; reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    alu("add_ovf",  T_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    alu("sub_zero", T_SUB,  32'h5, 32'h5, 32'h0, 1'b0);
    alu("sub_ovf",  T_SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
    alu("add_neg",  T_ADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    alu("addu",     T_ADDU, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    alu("subu",     T_SUBU, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
    alu("and",      T_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    alu("or",       T_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
    alu("xor",      T_XOR,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
    alu("nor0",     T_NOR,  32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    alu("nor1",     T_NOR,  32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    alu("sltu",     T_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    alu("slt",      T_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);

    md("mult_neg", T_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_busy(n);
    chk("mult_busy_len", 64'(n), 64'(MD_LAT));
    alu("mflo", T_MFLO, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b0);
    alu("mfhi", T_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);

    md("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_busy(n);
    md("mult_mostneg", T_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_busy(n);

`ifdef ULA_DIV_EN
    md("div_signed", T_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_busy(n);
    chk("div_busy_len", 64'(n), 64'(MD_LAT));
    md("div_mostneg", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_busy(n);
    md("divu", T_DIVU, 32'h7, 32'h2, 32'h1, 32'h3);
    wait_busy(n);
    send("div_by_zero", T_DIV, 32'h7, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 0, exp_hi, exp_lo);
    chk("div_by_zero.busy", 64'(busy), 0);
    send("divu_by_zero", T_DIVU, 32'h9, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 0, exp_hi, exp_lo);
    chk("divu_by_zero.busy", 64'(busy), 0);
`else
    send("div_disabled", T_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, 32'h0, 1'b0, 1'b0, 0, exp_hi, exp_lo);
    chk("div_disabled.busy", 64'(busy), 0);
    send("divu_disabled", T_DIVU, 32'h7, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 0, exp_hi, exp_lo);
    chk("divu_disabled.busy", 64'(busy), 0);
`endif

    // A request while busy must be dropped; operand changes must not disturb the latched ones.
    md("multu_ign", T_MULTU, 32'h3, 32'h5, 32'h0, 32'hF);
    repeat (4) @(negedge clock);
    start = 1'b1; op = T_ADD; a = 32'h1; b = 32'h2;
    @(negedge clock);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    wait_busy(n);
    repeat (3) @(negedge clock);

    // Abort a multiply with reset mid-run: no done, HI/LO cleared.
    send("multu_abort", T_MULTU, 32'h1234_5678, 32'h9, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 32'h0);
    repeat (8) @(negedge clock);
    chk("abort.busy_before", 64'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    check_zero("abort_reset");
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (40) @(negedge clock);
    alu("mflo_after_reset", T_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clock);

    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
